// File: rtl/aes_pkg.sv
// Shared definitions for the AES-256-CBC ingress padder: key/block geometry and padder states.
// AES256_KEY_LENGTH and AES_BLOCK_SIZE can be overridden from the build before this file.
`ifndef AES256_KEY_LENGTH
`define AES256_KEY_LENGTH 256
`endif
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

package aes_pkg;

    localparam int KEY_BEATS       = 4;
    localparam int IV_BEATS        = 2;
    localparam int BEATS_PER_BLOCK = 2;

    typedef enum logic [3:0] {
        ST_KEY  = 4'b0001,
        ST_IV   = 4'b0010,
        ST_DATA = 4'b0100,
        ST_PAD  = 4'b1000
    } pad_state_e;

    // Bytes of PKCS#7 padding needed to close the current block; a block that
    // ends exactly full still gets a whole extra block of 16.
    function automatic logic [4:0] pkcs7_pad_len(input logic half, input logic [3:0] k);
        logic [4:0] len;
        len = 5'd16 - {1'b0, half, 3'b000} - {1'b0, k};
        if (len == 5'd0) begin
            len = 5'd16;
        end
        return len;
    endfunction

endpackage

// File: rtl/aes_pkcs7_beat_fill.sv
// Fills the unused upper bytes of a partial last beat with the PKCS#7 pad value.
// With AES_PAD_ERR_CHECK_EN it also reports whether tkeep is contiguous from the LSB.
module aes_pkcs7_beat_fill (
    input  logic [63:0] data_i,
    input  logic [7:0]  keep_i,
    input  logic [4:0]  pad_n_i,
    output logic [63:0] data_o,
    output logic [3:0]  k_o
`ifdef AES_PAD_ERR_CHECK_EN
    ,
    output logic        contig_o
`endif
);

    always_comb begin
        k_o = '0;
        for (int i = 0; i < 8; i++) begin
            k_o = k_o + {3'b000, keep_i[i]};
        end
    end

    // Positions at or above the byte count take the pad value, regardless of tkeep shape.
    always_comb begin
        data_o = data_i;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) >= k_o) begin
                data_o[8*i +: 8] = {3'b000, pad_n_i};
            end
        end
    end

`ifdef AES_PAD_ERR_CHECK_EN
    logic [7:0] keep_inc;

    // A mask of the form 2^k-1 has no bit in common with itself plus one.
    assign keep_inc = keep_i + 8'd1;
    assign contig_o = ((keep_i & keep_inc) == 8'd0);
`endif

endmodule

// File: rtl/aes256_cbc_pkcs7_padder.sv
// AXI-Stream framer ahead of the AES-256-CBC core: passes key/IV/payload, appends PKCS#7 padding when encrypting.
// Define AES_PAD_ERR_CHECK_EN to add the sticky Err output for malformed input framing.
module aes256_cbc_pkcs7_padder
    import aes_pkg::*;
#(
    parameter int AXIS_WIDTH = 64,
    parameter int KEY_LENGTH = `AES256_KEY_LENGTH,
    parameter int BLOCK_SIZE = `AES_BLOCK_SIZE
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    S_axis_tvalid,
    output logic                    S_axis_tready,
    input  logic [AXIS_WIDTH-1:0]   S_axis_tdata,
    input  logic [AXIS_WIDTH/8-1:0] S_axis_tkeep,
    input  logic                    S_axis_tlast,
    input  logic                    S_axis_tuser,
    output logic                    M_axis_tvalid,
    input  logic                    M_axis_tready,
    output logic [AXIS_WIDTH-1:0]   M_axis_tdata,
    output logic [AXIS_WIDTH/8-1:0] M_axis_tkeep,
    output logic                    M_axis_tlast,
    output logic                    M_axis_tuser
`ifdef AES_PAD_ERR_CHECK_EN
    ,
    output logic                    Err
`endif
);

    if (AXIS_WIDTH != 64) begin : g_bad_width
        $error("aes256_cbc_pkcs7_padder supports only AXIS_WIDTH = 64");
    end
    if ((KEY_LENGTH / AXIS_WIDTH != KEY_BEATS) || (BLOCK_SIZE / AXIS_WIDTH != BEATS_PER_BLOCK)) begin : g_bad_geom
        $error("aes256_cbc_pkcs7_padder key/block geometry does not match the beat counts");
    end

    pad_state_e state_q;
    logic [1:0] beat_cnt_q;
    logic       mode_q;
    logic       half_q;
    logic [4:0] pad_n_q;
    logic [1:0] pad_left_q;

    logic                  s_xfer;
    logic [3:0]            last_k;
    logic [4:0]            pad_n_d;
    logic [1:0]            extra_d;
    logic [AXIS_WIDTH-1:0] fill_data;
`ifdef AES_PAD_ERR_CHECK_EN
    logic                  keep_contig;
    logic                  err_q;
`endif

    aes_pkcs7_beat_fill u_fill (
        .data_i   (S_axis_tdata),
        .keep_i   (S_axis_tkeep),
        .pad_n_i  (pad_n_d),
        .data_o   (fill_data),
        .k_o      (last_k)
`ifdef AES_PAD_ERR_CHECK_EN
        ,
        .contig_o (keep_contig)
`endif
    );

    assign s_xfer = S_axis_tvalid && S_axis_tready;

    // Extra whole pad beats after the last payload beat: none if it closes a
    // block with room left, one to finish a half block, two for a full block.
    always_comb begin
        pad_n_d = pkcs7_pad_len(half_q, last_k);
        if (!half_q) begin
            extra_d = 2'd1;
        end else if (last_k == 4'd8) begin
            extra_d = 2'd2;
        end else begin
            extra_d = 2'd0;
        end
    end

    always_comb begin
        S_axis_tready = 1'b0;
        M_axis_tvalid = 1'b0;
        M_axis_tdata  = S_axis_tdata;
        M_axis_tlast  = 1'b0;
        M_axis_tuser  = 1'b0;
        if (!Rst) begin
            unique case (state_q)
                ST_KEY: begin
                    S_axis_tready = M_axis_tready;
                    M_axis_tvalid = S_axis_tvalid;
                    M_axis_tuser  = (beat_cnt_q == 2'd0) ? S_axis_tuser : mode_q;
                end
                ST_IV: begin
                    S_axis_tready = M_axis_tready;
                    M_axis_tvalid = S_axis_tvalid;
                    M_axis_tuser  = mode_q;
                end
                ST_DATA: begin
                    S_axis_tready = M_axis_tready;
                    M_axis_tvalid = S_axis_tvalid;
                    M_axis_tuser  = mode_q;
                    if (S_axis_tlast) begin
                        if (mode_q) begin
                            M_axis_tdata = fill_data;
                            M_axis_tlast = (extra_d == 2'd0);
                        end else begin
                            M_axis_tlast = 1'b1;
                        end
                    end
                end
                ST_PAD: begin
                    M_axis_tvalid = 1'b1;
                    M_axis_tdata  = {(AXIS_WIDTH/8){{3'b000, pad_n_q}}};
                    M_axis_tlast  = (pad_left_q == 2'd1);
                    M_axis_tuser  = mode_q;
                end
                default: begin
                    S_axis_tready = 1'b0;
                end
            endcase
        end
        M_axis_tkeep = M_axis_tvalid ? '1 : '0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_KEY;
            beat_cnt_q <= '0;
            mode_q     <= 1'b0;
            half_q     <= 1'b0;
            pad_n_q    <= '0;
            pad_left_q <= '0;
        end else begin
            unique case (state_q)
                ST_KEY: begin
                    if (s_xfer) begin
                        if (beat_cnt_q == 2'd0) begin
                            mode_q <= S_axis_tuser;
                        end
                        if (beat_cnt_q == 2'(KEY_BEATS - 1)) begin
                            beat_cnt_q <= '0;
                            state_q    <= ST_IV;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 2'd1;
                        end
                    end
                end
                ST_IV: begin
                    if (s_xfer) begin
                        if (beat_cnt_q == 2'(IV_BEATS - 1)) begin
                            beat_cnt_q <= '0;
                            half_q     <= 1'b0;
                            // An empty encrypt payload still needs one full pad block.
                            if (S_axis_tlast && mode_q) begin
                                state_q    <= ST_PAD;
                                pad_n_q    <= 5'd16;
                                pad_left_q <= 2'd2;
                            end else begin
                                state_q <= ST_DATA;
                            end
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 2'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (s_xfer) begin
                        half_q <= ~half_q;
                        if (S_axis_tlast) begin
                            if (mode_q && (extra_d != 2'd0)) begin
                                state_q    <= ST_PAD;
                                pad_n_q    <= pad_n_d;
                                pad_left_q <= extra_d;
                            end else begin
                                state_q <= ST_KEY;
                                half_q  <= 1'b0;
                            end
                        end
                    end
                end
                ST_PAD: begin
                    if (M_axis_tready) begin
                        if (pad_left_q <= 2'd1) begin
                            state_q <= ST_KEY;
                        end
                        pad_left_q <= pad_left_q - 2'd1;
                    end
                end
                default: begin
                    state_q <= ST_KEY;
                end
            endcase
        end
    end

`ifdef AES_PAD_ERR_CHECK_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            err_q <= 1'b0;
        end else if (s_xfer) begin
            unique case (state_q)
                ST_KEY: begin
                    if (S_axis_tlast) begin
                        err_q <= 1'b1;
                    end
                end
                ST_IV: begin
                    if (S_axis_tlast && (beat_cnt_q == 2'd0)) begin
                        err_q <= 1'b1;
                    end
                end
                ST_DATA: begin
                    // Ciphertext must be whole blocks: last beat on the odd word and full.
                    if (!keep_contig || (S_axis_tkeep == '0)
                        || (!S_axis_tlast && (S_axis_tkeep != '1))
                        || (S_axis_tlast && !mode_q && (!half_q || (last_k != 4'd8)))) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    err_q <= err_q;
                end
            endcase
        end
    end

    assign Err = err_q;
`endif

endmodule

// File: tb/tb_aes256_cbc_pkcs7_padder.sv
// Self-checking bench for aes256_cbc_pkcs7_padder: byte-level packet model feeding a scoreboard queue.
// Build with AES_PAD_ERR_CHECK_EN to also exercise the Err output.
module tb_aes256_cbc_pkcs7_padder;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        S_axis_tvalid;
    logic        S_axis_tready;
    logic [63:0] S_axis_tdata;
    logic [7:0]  S_axis_tkeep;
    logic        S_axis_tlast;
    logic        S_axis_tuser;
    logic        M_axis_tvalid;
    logic        M_axis_tready;
    logic [63:0] M_axis_tdata;
    logic [7:0]  M_axis_tkeep;
    logic        M_axis_tlast;
    logic        M_axis_tuser;
`ifdef AES_PAD_ERR_CHECK_EN
    logic        Err;
`endif

    always #5 Clk = ~Clk;

    aes256_cbc_pkcs7_padder dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .S_axis_tvalid (S_axis_tvalid),
        .S_axis_tready (S_axis_tready),
        .S_axis_tdata  (S_axis_tdata),
        .S_axis_tkeep  (S_axis_tkeep),
        .S_axis_tlast  (S_axis_tlast),
        .S_axis_tuser  (S_axis_tuser),
        .M_axis_tvalid (M_axis_tvalid),
        .M_axis_tready (M_axis_tready),
        .M_axis_tdata  (M_axis_tdata),
        .M_axis_tkeep  (M_axis_tkeep),
        .M_axis_tlast  (M_axis_tlast),
        .M_axis_tuser  (M_axis_tuser)
`ifdef AES_PAD_ERR_CHECK_EN
        ,
        .Err           (Err)
`endif
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        user;
        logic        pad;
        logic        text;
    } beat_t;

    typedef struct {
        logic        mode;
        int          nbytes;
        int          exp_text;
        logic [63:0] exp_final;
        int          bp;
    } vec_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          bp_mode = 0;
    bit          pad_stalled = 1'b0;
    bit          pt_stalled = 1'b0;
    int          pkt_text_beats = 0;
    logic [63:0] pkt_final = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] d, input logic l, input logic u, input logic p, input logic t);
        beat_t e;
        e.data = d; e.last = l; e.user = u; e.pad = p; e.text = t;
        exp_q.push_back(e);
    endtask

    // Output monitor: scoreboard pops, handshake rules and hold stability.
    initial begin
        beat_t       e;
        logic        hold_v = 1'b0;
        logic [63:0] hold_d = '0;
        logic        hold_l = 1'b0;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                hold_v = 1'b0;
            end else begin
                if (exp_q.size() > 0 && exp_q[0].pad) begin
                    check("pad_valid", 64'(M_axis_tvalid), 64'd1);
                    check("pad_s_ready", 64'(S_axis_tready), 64'd0);
                end else begin
                    check("s_ready_follows", 64'(S_axis_tready), 64'(M_axis_tready));
                end
                check("tkeep", 64'(M_axis_tkeep), M_axis_tvalid ? 64'hFF : 64'h00);
                if (hold_v) begin
                    check("hold_data", M_axis_tdata, hold_d);
                    check("hold_last", 64'(M_axis_tlast), 64'(hold_l));
                end
                if (M_axis_tvalid && M_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", M_axis_tdata, 64'hDEAD_BEEF_DEAD_BEEF);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", M_axis_tdata, e.data);
                        check("beat_last", 64'(M_axis_tlast), 64'(e.last));
                        check("beat_user", 64'(M_axis_tuser), 64'(e.user));
                        if (e.text) begin
                            pkt_text_beats++;
                            if (M_axis_tlast) pkt_final = M_axis_tdata;
                        end
                    end
                end
                hold_v = M_axis_tvalid && !M_axis_tready;
                hold_d = M_axis_tdata;
                hold_l = M_axis_tlast;
            end
        end
    end

    // Downstream ready: always, random, or one 3-cycle stall in pass-through and in padding.
    initial begin
        M_axis_tready = 1'b1;
        forever begin
            @(posedge Clk); #1;
            if (bp_mode == 1) begin
                M_axis_tready = ($urandom_range(0, 3) != 0);
            end else if (bp_mode == 2 && exp_q.size() > 0 && !pt_stalled && !exp_q[0].pad) begin
                pt_stalled = 1'b1;
                M_axis_tready = 1'b0;
                repeat (3) begin @(posedge Clk); #1; end
                M_axis_tready = 1'b1;
            end else if (bp_mode == 2 && exp_q.size() > 0 && !pad_stalled && exp_q[0].pad) begin
                pad_stalled = 1'b1;
                M_axis_tready = 1'b0;
                repeat (3) begin @(posedge Clk); #1; end
                M_axis_tready = 1'b1;
            end else begin
                M_axis_tready = 1'b1;
            end
        end
    end

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        int n = 0;
        S_axis_tvalid = 1'b1; S_axis_tdata = d; S_axis_tkeep = k; S_axis_tlast = l; S_axis_tuser = u;
        do begin
            @(negedge Clk);
            n++;
        end while (!S_axis_tready && n < 100);
        if (!S_axis_tready) begin
            checks++; errors++;
            $display("FAIL drive_timeout: s_ready %b required 1", S_axis_tready);
        end
        @(posedge Clk); #1;
        S_axis_tvalid = 1'b0;
        S_axis_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d beats left required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge Clk); #1;
    endtask

    // Builds the expected output at byte level (payload then PKCS#7 bytes), then drives the packet.
    task automatic send_packet(input logic mode, input int nbytes);
        logic [7:0]  pay[$];
        logic [7:0]  ob[$];
        logic [63:0] in_d[$];
        logic [7:0]  in_k[$];
        logic [63:0] key[4];
        logic [63:0] iv[2];
        int          nin, total;
        pad_stalled = 1'b0;
        pt_stalled  = 1'b0;
        pkt_text_beats = 0;
        pkt_final = '0;
        for (int j = 0; j < nbytes; j++) pay.push_back(8'(j + 1));
        nin = (nbytes + 7) / 8;
        for (int b = 0; b < nin; b++) begin
            logic [63:0] d;
            logic [7:0]  k;
            d = '0; k = '0;
            for (int j = 0; j < 8; j++) begin
                if (8*b + j < nbytes) begin
                    d[8*j +: 8] = pay[8*b + j];
                    k[j] = 1'b1;
                end else begin
                    d[8*j +: 8] = 8'hEE;
                end
            end
            in_d.push_back(d);
            in_k.push_back(k);
        end
        for (int i = 0; i < 4; i++) begin
            key[i] = {$urandom, $urandom};
            push_exp(key[i], 1'b0, mode, 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            iv[i] = {$urandom, $urandom};
            push_exp(iv[i], 1'b0, mode, 1'b0, 1'b0);
        end
        if (mode) begin
            total = (nbytes / 16 + 1) * 16;
            for (int j = 0; j < total; j++) ob.push_back((j < nbytes) ? pay[j] : 8'(total - nbytes));
            for (int b = 0; b < total / 8; b++) begin
                logic [63:0] d;
                for (int j = 0; j < 8; j++) d[8*j +: 8] = ob[8*b + j];
                push_exp(d, b == total / 8 - 1, mode, b >= nin, 1'b1);
            end
        end else begin
            for (int b = 0; b < nin; b++) push_exp(in_d[b], b == nin - 1, mode, 1'b0, 1'b1);
        end
        // tuser is only honoured on key beat 0; later key beats carry the opposite value.
        for (int i = 0; i < 4; i++) drive_beat(key[i], 8'hFF, 1'b0, (i == 0) ? mode : ~mode);
        drive_beat(iv[0], 8'hFF, 1'b0, mode);
        drive_beat(iv[1], 8'hFF, nbytes == 0, mode);
        for (int b = 0; b < nin; b++) drive_beat(in_d[b], in_k[b], b == nin - 1, mode);
        wait_drain();
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1,  5, 2, 64'h0B0B0B0B0B0B0B0B, 0};
        vecs[1] = '{1'b1, 16, 4, 64'h1010101010101010, 2};
        vecs[2] = '{1'b1,  0, 2, 64'h1010101010101010, 0};
        vecs[3] = '{1'b1, 12, 2, 64'h040404040C0B0A09, 2};
        vecs[4] = '{1'b1,  8, 2, 64'h0808080808080808, 1};
        vecs[5] = '{1'b0, 32, 4, 64'h201F1E1D1C1B1A19, 2};
        vecs[6] = '{1'b1, 15, 2, 64'h010F0E0D0C0B0A09, 1};
        vecs[7] = '{1'b1, 23, 4, 64'h0909090909090909, 2};
        vecs[8] = '{1'b0, 16, 2, 64'h100F0E0D0C0B0A09, 1};

        Rst = 1'b1;
        S_axis_tvalid = 1'b1; S_axis_tdata = 64'h0123456789ABCDEF; S_axis_tkeep = 8'hFF;
        S_axis_tlast = 1'b1; S_axis_tuser = 1'b1;
        repeat (2) begin
            @(negedge Clk);
            check("rst_s_ready", 64'(S_axis_tready), 64'd0);
            check("rst_m_valid", 64'(M_axis_tvalid), 64'd0);
            check("rst_m_last", 64'(M_axis_tlast), 64'd0);
            check("rst_m_user", 64'(M_axis_tuser), 64'd0);
        end
        @(posedge Clk); #1;
        Rst = 1'b0; S_axis_tvalid = 1'b0; S_axis_tlast = 1'b0;
        @(negedge Clk);
        check("idle_m_valid", 64'(M_axis_tvalid), 64'd0);
        check("idle_s_ready", 64'(S_axis_tready), 64'd1);
        @(posedge Clk); #1;

        for (int v = 0; v < 9; v++) begin
            bp_mode = vecs[v].bp;
            send_packet(vecs[v].mode, vecs[v].nbytes);
            check($sformatf("vec%0d_text_beats", v), 64'(pkt_text_beats), 64'(vecs[v].exp_text));
            check($sformatf("vec%0d_final_beat", v), pkt_final, vecs[v].exp_final);
        end
        bp_mode = 0;

        // Reset after IV beat 0: the packet is abandoned and the next one frames from scratch.
        for (int i = 0; i < 5; i++) push_exp(64'h1111_0000_0000_0000 + 64'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive_beat(64'h1111_0000_0000_0000 + 64'(i), 8'hFF, 1'b0, 1'b1);
        Rst = 1'b1;
        S_axis_tvalid = 1'b1; S_axis_tdata = 64'h2222; S_axis_tlast = 1'b1;
        @(negedge Clk);
        check("midrst_s_ready", 64'(S_axis_tready), 64'd0);
        check("midrst_m_valid", 64'(M_axis_tvalid), 64'd0);
        check("midrst_beats_out", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge Clk); #1;
        Rst = 1'b0; S_axis_tvalid = 1'b0; S_axis_tlast = 1'b0;
        send_packet(1'b1, 5);
        check("postrst_text_beats", 64'(pkt_text_beats), 64'd2);
        check("postrst_final_beat", pkt_final, 64'h0B0B0B0B0B0B0B0B);

`ifdef AES_PAD_ERR_CHECK_EN
        @(negedge Clk);
        check("err_clean", 64'(Err), 64'd0);
        @(posedge Clk); #1;
        send_packet(1'b0, 12);
        @(negedge Clk);
        check("err_dec12", 64'(Err), 64'd1);
        @(posedge Clk); #1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes256_cbc_pkcs7_padder.md
Name: aes256_cbc_pkcs7_padder

Overview:
Ingress framer sitting directly upstream of the iterative AES-256-CBC core. It accepts one packet per operation on a 64-bit AXI-Stream: key words, then IV words, then a byte-granular payload. Key, IV and payload are forwarded in the exact beat order the core consumes. In encrypt mode the payload is extended with PKCS#7 padding to a whole number of 128-bit blocks, and tlast is moved to the final padded beat. In decrypt mode the payload is passed through unchanged.

Parameters:
AXIS_WIDTH, 64, beat width in bits; only 64 is supported (elaboration error otherwise).
KEY_LENGTH, 256, key bits; the key occupies KEY_LENGTH/AXIS_WIDTH = 4 beats.
BLOCK_SIZE, 128, AES block bits; one block is 2 beats.

Ports:
Clk  in  1  clock
Rst  in  1  reset, synchronous, active-high
S_axis_tvalid  in  1  upstream valid
S_axis_tready  out  1  upstream ready
S_axis_tdata  in  64  byte i at [8i+7:8i]
S_axis_tkeep  in  8  byte enables; contiguous from LSB; only partial on the last payload beat
S_axis_tlast  in  1  marks the last payload beat (or the last IV beat for an empty payload)
S_axis_tuser  in  1  1 = encrypt, 0 = decrypt; sampled on key beat 0
M_axis_tvalid  out  1  to core
M_axis_tready  in  1  from core
M_axis_tdata  out  64  forwarded or padded data
M_axis_tkeep  out  8  always 8'hFF while valid, else 0
M_axis_tlast  out  1  asserted only on the final text beat
M_axis_tuser  out  1  packet mode
Err  out  1  present only with AES_PAD_ERR_CHECK_EN

Behaviour:
- Reset: Rst is synchronous, active-high, on Clk. During Rst, S_axis_tready=0 and M_axis_tvalid/tlast/tuser=0. After reset: state ST_KEY, all counters 0, mode_reg=0, half_reg=0.
- Reset mid-packet aborts the packet. Nothing is flushed; the block restarts in ST_KEY.
- States: ST_KEY, ST_IV, ST_DATA, ST_PAD.
- ST_KEY, ST_IV, ST_DATA: zero-latency combinational pass-through.
  - M_axis_tvalid = S_axis_tvalid and S_axis_tready = M_axis_tready.
  - A transfer occurs when both valid and ready are high.
- ST_KEY:
  - Count 4 transfers, then go to ST_IV.
  - On beat 0, mode_reg <= S_axis_tuser and M_axis_tuser = S_axis_tuser directly; on all later beats M_axis_tuser = mode_reg.
  - Input tlast is ignored; M_axis_tlast=0.
- ST_IV:
  - Count 2 transfers, then go to ST_DATA; M_axis_tlast=0.
  - Encrypt with tlast on IV beat 1 (empty payload): go to ST_PAD with pad_n=16 and 2 pad beats.
  - Decrypt with tlast on an IV beat: tlast is dropped, and the block waits in ST_DATA.
- ST_DATA:
  - half_reg toggles on each transfer and tracks the word index within the current block.
  - Non-last beats are forwarded unchanged.
- Last beat, encrypt mode: let k = popcount(tkeep), 1..8, and pad_n = 16 - (8*half_reg + k).
  - Bytes k..7 of the output beat are replaced with pad_n.
  - Number of extra beats: 0 if half_reg=1 and k<8; 1 if half_reg=0; 2 if half_reg=1 and k=8 (pad_n=16).
  - With 0 extra beats, M_axis_tlast=1 and the next state is ST_KEY. Otherwise M_axis_tlast=0 on this beat and the next state is ST_PAD.
- Last beat, decrypt mode: forwarded unchanged with tlast=1; next state ST_KEY.
- ST_PAD:
  - S_axis_tready=0; M_axis_tvalid=1; M_axis_tdata = {8{pad_n}}.
  - Remaining-beat counter is 1 or 2; M_axis_tlast=1 on the final pad beat; then go to ST_KEY.
  - Data must stay stable while M_axis_tready=0.
- Payload length is unbounded; half_reg wraps modulo 2.
- Latency is 0 cycles for pass-through. Pad beats follow back-to-back, one per cycle when M_axis_tready=1.

Optional Feature:
Macro AES_PAD_ERR_CHECK_EN.
- Defined: adds the Err output, a registered signal that is cleared only by Rst. Err is set on any of:
  - non-contiguous tkeep;
  - tkeep != 8'hFF on a non-last payload beat;
  - tkeep=0;
  - a decrypt payload that is not a multiple of 16 bytes (last beat has half_reg=0 or k<8);
  - tlast in ST_KEY, or on IV beat 0.
- Data flow is unaffected by error detection.
- Undefined: no Err port, no checks; malformed input produces undefined padding but the FSM never deadlocks.

Decomposition:
- aes_defines.svh supplies AES256_KEY_LENGTH and AES_BLOCK_SIZE.
- New package aes_pkg holds: typedef of the one-hot padder state enum; localparams KEY_BEATS=4, IV_BEATS=2, BEATS_PER_BLOCK=2.
- One combinational sub-module, aes_pkcs7_beat_fill. Inputs: data, keep and pad_n. Output: the filled beat. It also reports k and tkeep contiguity for the checker.

Test Plan:
- Encrypt, 5-byte payload: data beat 64'h0000000504030201, tkeep=8'h1F, tlast. Expect beat 64'h0B0B0B0504030201 with tlast=0, then 64'h0B0B0B0B0B0B0B0B with tlast=1. M_axis_tuser=1 on all 8 output beats.
- Encrypt, 16-byte payload (two full beats, tlast on the 2nd). Expect both forwarded with tlast=0, then two beats of 64'h1010101010101010 with tlast on the last. Empty encrypt payload (tlast on IV beat 1) gives the same two 0x10 beats.
- Encrypt, 12 bytes: beat 0 full, beat 1 with tkeep=8'h0F. Expect beat 1 upper bytes = 0x04 and tlast=1 on it, with no ST_PAD cycle. Encrypt, 8 bytes (one full beat): expect one beat 64'h0808080808080808 with tlast.
- Decrypt, 32 bytes: 4 beats forwarded bit-exact. Expect M_axis_tuser=0 throughout, tlast only on the 4th data beat, tkeep=FF; Err stays 0.
- Backpressure: M_axis_tready low for 3 cycles during ST_PAD and during pass-through. Expect tdata/tlast stable and S_axis_tready=0 (ST_PAD) or following M_axis_tready (pass-through).
- Rst asserted after IV beat 0 → S_axis_tready=0 that cycle; then a full new packet is framed correctly. With the macro defined: decrypt 12-byte payload → Err=1 at the cycle after the last beat.
